swervolf_bin2bcd_disp: RTL and testbench

// Wishbone peripheral that sits upstream of the eight-digit seven-segment display controller.

---
 rtl/swervolf_bin2bcd_disp.sv | 150 +++++++++++++++
 tb/tb_swervolf_bin2bcd_disp.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/swervolf_bin2bcd_disp.sv
// rtl/swervolf_bin2bcd_disp.sv - Wishbone binary-to-BCD converter driving the seven-segment display
module swervolf_bin2bcd_disp #(
    parameter int BIN_WIDTH = 27,
    parameter int N_DIGITS  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [3:0]              i_wb_adr,
    input  logic [31:0]             i_wb_dat,
    input  logic [3:0]              i_wb_sel,
    input  logic                    i_wb_we,
    input  logic                    i_wb_cyc,
    input  logic                    i_wb_stb,
    output logic [31:0]             o_wb_rdt,
    output logic                    o_wb_ack,
    output logic [4*N_DIGITS-1:0]   o_digits,
    output logic [N_DIGITS-1:0]     o_enables,
    output logic                    o_done_irq
);

    localparam int DW = 4 * N_DIGITS;
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0] MAX_VAL = 64'(10 ** N_DIGITS) - 64'd1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q;
    logic [BIN_WIDTH-1:0]   bin_q, bin_d, shreg_q;
    logic [DW-1:0]          bcd_q, bcd_d, digits_q;
    logic [CW-1:0]          cnt_q;
    logic                   blank_en_q;
    logic [7:0]             mask_q;
    logic                   start_q, done_q, ovf_q, irq_q, ack_q;
    logic [31:0]            rdt_q, rdt_d;
    logic [31:0]            bin_wr;
    logic [N_DIGITS-1:0]    en_d;
    logic                   accept, wr_bin, wr_ctrl, busy;
    logic                   unused_ok;

    assign accept  = i_wb_cyc & i_wb_stb & ~ack_q;
    assign wr_bin  = accept & i_wb_we & (i_wb_adr[3:2] == 2'd0);
    assign wr_ctrl = accept & i_wb_we & (i_wb_adr[3:2] == 2'd1);
    assign busy    = (state_q == SHIFT);
    assign unused_ok = ^{i_wb_adr[1:0], bin_wr[31:BIN_WIDTH]};

    // Byte-lane merge of the write data onto the current BIN value
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            bin_wr[8*b +: 8] = i_wb_sel[b] ? i_wb_dat[8*b +: 8] : 8'(32'(bin_q) >> (8*b));
        end
        bin_d = bin_wr[BIN_WIDTH-1:0];
    end

    // One double-dabble step: correct every nibble in parallel, then shift in the next bit
    always_comb begin
        logic [DW-1:0] adj;
        adj = bcd_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d = {adj[DW-2:0], shreg_q[BIN_WIDTH-1]};
    end

    always_comb begin
        rdt_d = 32'd0;
        case (i_wb_adr[3:2])
            2'd0: rdt_d = 32'(bin_q);
            2'd1: rdt_d = {16'd0, mask_q, 7'd0, blank_en_q};
            2'd2: rdt_d = {29'd0, ovf_q, done_q, busy};
            default: rdt_d = 32'(digits_q);
        endcase
    end

    // A digit stays lit when blanking is off, it is digit 0, or any digit at or above it is nonzero
    always_comb begin
        logic lit;
        en_d = '1;
        lit  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            lit      = ~blank_en_q | (i == 0) | (|(digits_q >> (4*i)));
            en_d[i]  = ~(lit & mask_q[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            shreg_q    <= '0;
            bcd_q      <= '0;
            digits_q   <= '0;
            cnt_q      <= '0;
            blank_en_q <= 1'b1;
            mask_q     <= 8'hFF;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
            ack_q      <= 1'b0;
            rdt_q      <= '0;
        end else begin
            ack_q   <= i_wb_cyc & ~ack_q;
            irq_q   <= 1'b0;
            start_q <= wr_bin;
            if (accept) begin
                rdt_q <= rdt_d;
            end
            if (wr_bin) begin
                bin_q <= bin_d;
            end
            if (wr_ctrl) begin
                if (i_wb_sel[0]) blank_en_q <= i_wb_dat[0];
                if (i_wb_sel[1]) mask_q     <= i_wb_dat[15:8];
            end
            // A pending start always wins; a BIN write during SHIFT freezes the old run until the restart
            if (start_q) begin
                done_q <= 1'b0;
                if (64'(bin_q) > MAX_VAL) begin
                    ovf_q   <= 1'b1;
                    state_q <= IDLE;
                end else begin
                    ovf_q   <= 1'b0;
                    bcd_q   <= '0;
                    shreg_q <= bin_q;
                    cnt_q   <= CW'(BIN_WIDTH);
                    state_q <= SHIFT;
                end
            end else if (state_q == SHIFT && !wr_bin) begin
                bcd_q   <= bcd_d;
                shreg_q <= shreg_q << 1;
                cnt_q   <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    digits_q <= bcd_d;
                    done_q   <= 1'b1;
                    irq_q    <= 1'b1;
                    state_q  <= IDLE;
                end
            end
        end
    end

    assign o_wb_rdt   = rdt_q;
    assign o_wb_ack   = ack_q;
    assign o_digits   = digits_q;
    assign o_enables  = en_d;
    assign o_done_irq = irq_q;

endmodule

// File: tb/tb_swervolf_bin2bcd_disp.sv
// tb/tb_swervolf_bin2bcd_disp.sv - self-checking bench for swervolf_bin2bcd_disp
module tb_swervolf_bin2bcd_disp;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [3:0]  i_wb_adr = '0;
    logic [31:0] i_wb_dat = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        i_wb_we = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic [31:0] o_digits;
    logic [7:0]  o_enables;
    logic        o_done_irq;

    swervolf_bin2bcd_disp dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
        .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
        .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
        .o_digits(o_digits), .o_enables(o_enables), .o_done_irq(o_done_irq)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    int irq_at[$];

    always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge i_clk) if (o_done_irq) irq_at.push_back(cyc_cnt);

    typedef struct {
        int unsigned bin;
        bit          blank;
        logic [7:0]  mask;
        logic [31:0] exp_digits;
        logic [7:0]  exp_en;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_to(input int k);
        while (cyc_cnt < k) @(negedge i_clk);
    endtask

    // Accepted at edge T (returned); returns at the negedge after T+1
    task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel, output int t);
        i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
        i_wb_we = 1'b1; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        t = cyc_cnt;
        i_wb_we = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [31:0] dat);
        i_wb_adr = adr; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        dat = o_wb_rdt;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        @(negedge i_clk);
    endtask

    function automatic logic [31:0] bcd_model(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] en_model(input int unsigned v, input bit blank, input logic [7:0] mask);
        int nd;
        int unsigned x;
        logic [7:0] e;
        nd = 1;
        x = v / 10;
        while (x != 0) begin
            nd++;
            x = x / 10;
        end
        for (int i = 0; i < 8; i++) e[i] = ~((!blank || i < nd) & mask[i]);
        return e;
    endfunction

    int t, t2;
    logic [31:0] rd;
    int unsigned shown;
    bit cur_blank;
    logic [7:0] cur_mask;

    initial begin
        tbl[0]  = '{32'd12345678,  1'b1, 8'hFF, 32'h12345678, 8'h00};
        tbl[1]  = '{32'd905,       1'b1, 8'hFF, 32'h00000905, 8'hF8};
        tbl[2]  = '{32'd905,       1'b0, 8'h0F, 32'h00000905, 8'hF0};
        tbl[3]  = '{32'd0,         1'b1, 8'hFF, 32'h00000000, 8'hFE};
        tbl[4]  = '{32'd0,         1'b0, 8'hFF, 32'h00000000, 8'h00};
        tbl[5]  = '{32'd99999999,  1'b1, 8'hFF, 32'h99999999, 8'h00};
        tbl[6]  = '{32'd42,        1'b1, 8'hFF, 32'h00000042, 8'hFC};
        tbl[7]  = '{32'd10000000,  1'b1, 8'hF0, 32'h10000000, 8'h0F};
        tbl[8]  = '{32'd1000,      1'b1, 8'hFF, 32'h00001000, 8'hF0};
        tbl[9]  = '{32'd7,         1'b1, 8'h00, 32'h00000007, 8'hFF};
        tbl[10] = '{32'd50,        1'b1, 8'hFF, 32'h00000050, 8'hFC};

        repeat (3) @(negedge i_clk);
        chk("rst_digits", o_digits, 32'h0);
        chk("rst_enables", 32'(o_enables), 32'hFE);
        chk("rst_ack", 32'(o_wb_ack), 32'h0);
        chk("rst_irq", 32'(o_done_irq), 32'h0);
        i_rst = 1'b0;
        @(negedge i_clk);
        wb_read(4'h8, rd); chk("rst_status", rd, 32'h0);
        wb_read(4'h4, rd); chk("rst_ctrl", rd, 32'h0000FF01);
        wb_read(4'h0, rd); chk("rst_bin", rd, 32'h0);
        wb_read(4'hC, rd); chk("rst_result", rd, 32'h0);

        // Main conversion with exact-latency probes
        irq_at.delete();
        wb_write(4'h0, 32'd12345678, 4'hF, t);
        wb_read(4'h8, rd); chk("busy_at_T2", rd, 32'h1);
        wait_to(t + 27);
        chk("digits_before_T28", o_digits, 32'h0);
        wb_read(4'h8, rd); chk("busy_at_T28", rd, 32'h1);
        chk("digits_after_T28", o_digits, 32'h12345678);
        wb_read(4'h8, rd); chk("done_at_T30", rd, 32'h2);
        wb_read(4'hC, rd); chk("result_reg", rd, 32'h12345678);
        chk("irq_count_main", irq_at.size(), 1);
        if (irq_at.size() == 1) chk("irq_time_main", irq_at[0], t + 28);

        for (int k = 0; k < 11; k++) begin
            wb_write(4'h4, {16'd0, tbl[k].mask, 7'd0, tbl[k].blank}, 4'h3, t2);
            irq_at.delete();
            wb_write(4'h0, tbl[k].bin, 4'hF, t);
            wait_to(t + 30);
            chk($sformatf("tbl%0d_digits", k), o_digits, tbl[k].exp_digits);
            chk($sformatf("tbl%0d_enables", k), 32'(o_enables), 32'(tbl[k].exp_en));
            chk($sformatf("tbl%0d_irq_n", k), irq_at.size(), 1);
            if (irq_at.size() == 1) chk($sformatf("tbl%0d_irq_t", k), irq_at[0], t + 28);
        end
        shown = 50;

        // Overflow: nothing starts, display held
        wb_write(4'h4, 32'h0000FF01, 4'h3, t2);
        irq_at.delete();
        wb_write(4'h0, 32'd100000000, 4'hF, t);
        wb_read(4'h8, rd); chk("ovf_status", rd, 32'h4);
        wait_to(t + 32);
        chk("ovf_digits_held", o_digits, 32'h00000050);
        chk("ovf_no_irq", irq_at.size(), 0);

        // Byte-lane write: only lane 3 replaced, upper bits truncated -> out of range
        wb_write(4'h0, 32'd42, 4'hF, t);
        wait_to(t + 30);
        irq_at.delete();
        wb_write(4'h0, 32'hFFFFFFFF, 4'h8, t);
        wb_read(4'h0, rd); chk("lane_bin", rd, 32'h0700002A);
        wb_read(4'h8, rd); chk("lane_ovf", rd, 32'h4);
        wb_write(4'h0, 32'h0, 4'h8, t);
        wait_to(t + 30);
        chk("lane_digits", o_digits, 32'h00000042);
        chk("lane_irq", irq_at.size(), 1);

        // Abort: second write ten cycles into the first conversion
        irq_at.delete();
        wb_write(4'h0, 32'd99999999, 4'hF, t);
        wait_to(t + 9);
        wb_write(4'h0, 32'd42, 4'hF, t2);
        wait_to(t2 + 32);
        chk("abort_irq_n", irq_at.size(), 1);
        if (irq_at.size() == 1) chk("abort_irq_t", irq_at[0], t2 + 28);
        chk("abort_digits", o_digits, 32'h00000042);
        chk("abort_enables", 32'(o_enables), 32'hFC);

        // Randomized against the arithmetic model
        cur_blank = 1'b1;
        cur_mask = 8'hFF;
        shown = 42;
        for (int k = 0; k < 24; k++) begin
            int unsigned v;
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) v = $urandom_range(0, 999);
            else if (r == 9) v = 100000000 + $urandom_range(0, 34217727);
            else v = $urandom_range(0, 99999999);
            cur_blank = 1'($urandom_range(0, 1));
            cur_mask = 8'($urandom);
            wb_write(4'h4, {16'd0, cur_mask, 7'd0, cur_blank}, 4'h3, t2);
            irq_at.delete();
            wb_write(4'h0, v, 4'hF, t);
            wait_to(t + 30);
            if (v <= 99999999) begin
                shown = v;
                chk($sformatf("rnd%0d_irq_n", k), irq_at.size(), 1);
            end else begin
                chk($sformatf("rnd%0d_noirq", k), irq_at.size(), 0);
            end
            chk($sformatf("rnd%0d_digits", k), o_digits, bcd_model(shown));
            chk($sformatf("rnd%0d_enables", k), 32'(o_enables), 32'(en_model(shown, cur_blank, cur_mask)));
        end

        // Reset at cycle 15 of a conversion
        wb_write(4'h0, 32'd42, 4'hF, t);
        wait_to(t + 30);
        irq_at.delete();
        wb_write(4'h0, 32'd12345678, 4'hF, t);
        wait_to(t + 14);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("midrst_digits", o_digits, 32'h0);
        chk("midrst_enables", 32'(o_enables), 32'hFE);
        wb_read(4'h8, rd); chk("midrst_status", rd, 32'h0);
        wb_read(4'h4, rd); chk("midrst_ctrl", rd, 32'h0000FF01);
        wait_to(t + 40);
        chk("midrst_no_irq", irq_at.size(), 0);
        chk("midrst_digits_late", o_digits, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
